lut_neuron_cfg_loader: RTL and testbench

Run-time programmable counterpart to the generated fixed-ROM LUT neurons: an 8-input, 1-output truth-table neuron whose 256-entry table is written over a word-wide valid/ready configuration stream instead of being baked into RTL. It sits in the same layer position as a generated neuron and exposes the same inference semantics (8-bit code in, 1-bit activation out). It adds a registered inference path and a loader FSM that validates framing before arming the table.

---
 rtl/lut_neuron_pkg.sv | 22 ++
 rtl/lut_neuron_cfg_loader_table.sv | 36 +++
 rtl/lut_neuron_cfg_loader.sv | 115 +++++++++++
 tb/tb_lut_neuron_cfg_loader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/lut_neuron_pkg.sv
// Shared constants and FSM state type for the programmable LUT neuron.
package lut_neuron_pkg;

  // Neuron fan-in and configuration word width (defaults for the loader).
  localparam int IN_BITS = 8;
  localparam int CFG_W   = 32;

  // Table depth and number of configuration beats per full load.
  localparam int DEPTH   = 2 ** IN_BITS;
  localparam int WORDS   = DEPTH / CFG_W;

  // Beat counter width; kept at least one bit for the single-word case.
  localparam int BEAT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

  // Loader FSM states.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2
  } state_t;

endpackage

// File: rtl/lut_neuron_cfg_loader_table.sv
// Truth-table storage: word-wide write port, asynchronous 1-bit read port.
// Contents are never reset; validity is tracked by the loader.
module lut_table_ram #(
  parameter int IN_BITS = 8,
  parameter int CFG_W   = 32,
  parameter int BEAT_W  = 3
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [BEAT_W-1:0]  wr_addr,
  input  logic [CFG_W-1:0]   wr_data,
  input  logic [IN_BITS-1:0] rd_addr,
  output logic               rd_data
);

  localparam int WORDS = (2 ** IN_BITS) / CFG_W;
  localparam int SEL_W = $clog2(CFG_W);

  (* ram_style = "distributed", rom_style = "distributed" *)
  logic [CFG_W-1:0] mem [WORDS];

  logic [BEAT_W-1:0] rd_word;
  logic [SEL_W-1:0]  rd_sel;

  // Word write: bit j of word k holds table entry k*CFG_W + j.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_word = BEAT_W'(rd_addr >> SEL_W);
  assign rd_sel  = rd_addr[SEL_W-1:0];
  assign rd_data = mem[rd_word][rd_sel];

endmodule

// File: rtl/lut_neuron_cfg_loader.sv
// Run-time programmable 8-input LUT neuron. A loader FSM checks the framing
// of the configuration stream before arming the table; inference is a
// single registered lookup per cycle, masked to 0 while the table is unarmed.
//
// Handshake: a configuration beat transfers on a rising edge where
// cfg_valid && cfg_ready; cfg_ready drops only during the cfg_err pulse.
// The inference path has no backpressure: out_valid follows in_valid by one cycle.
module lut_neuron_cfg_loader
  import lut_neuron_pkg::*;
#(
  parameter int IN_BITS = lut_neuron_pkg::IN_BITS,
  parameter int CFG_W   = lut_neuron_pkg::CFG_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CFG_W-1:0]   cfg_data,
  input  logic               cfg_last,
  output logic               cfg_err,
  output logic               loaded,
  input  logic               in_valid,
  input  logic [IN_BITS-1:0] in_data,
  output logic               out_valid,
  output logic               out_data,
  output logic [1:0]         dbg_state
);

  localparam int DEPTH  = 2 ** IN_BITS;
  localparam int WORDS  = DEPTH / CFG_W;
  localparam int BEAT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [BEAT_W-1:0] pos;
  logic              err_q, err_d;
  logic              accept;
  logic              wr_en;
  logic              rd_bit;

  assign accept    = cfg_valid && cfg_ready;
  assign cfg_ready = ~err_q;
  assign cfg_err   = err_q;
  assign loaded    = (state_q == ST_ARMED);
  assign dbg_state = state_q;

  // Slot the current beat lands in: a beat outside LOAD always starts at 0.
  assign pos = (state_q == ST_LOAD) ? beat_q : '0;

  // Loader state, beat counter and error pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  // Framing check: cfg_last must appear exactly on the final slot.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    if (accept) begin
      if (cfg_last != (pos == LAST_BEAT)) begin
        // Bad framing: drop the word and forget any partial table.
        err_d   = 1'b1;
        state_d = ST_EMPTY;
        beat_d  = '0;
      end else begin
        wr_en = 1'b1;
        if (cfg_last) begin
          state_d = ST_ARMED;
          beat_d  = '0;
        end else begin
          state_d = ST_LOAD;
          beat_d  = pos + BEAT_W'(1);
        end
      end
    end
  end

  lut_table_ram #(
    .IN_BITS (IN_BITS),
    .CFG_W   (CFG_W),
    .BEAT_W  (BEAT_W)
  ) u_table (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (pos),
    .wr_data (cfg_data),
    .rd_addr (in_data),
    .rd_data (rd_bit)
  );

  // Registered lookup; reads the pre-write table and pre-update armed flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= loaded & rd_bit;
      end
    end
  end

endmodule

// File: tb/tb_lut_neuron_cfg_loader.sv
// Bench for the programmable LUT neuron: directed loads, framing errors,
// reloads and resets, checked every cycle against a protocol-level model.
module tb_lut_neuron_cfg_loader;
  import lut_neuron_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [CFG_W-1:0]   cfg_data;
  logic               cfg_last;
  logic               cfg_err;
  logic               loaded;
  logic               in_valid;
  logic [IN_BITS-1:0] in_data;
  logic               out_valid;
  logic               out_data;
  logic [1:0]         dbg_state;

  lut_neuron_cfg_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_last  (cfg_last),
    .cfg_err   (cfg_err),
    .loaded    (loaded),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Table as a flat bit array, count of beats taken in the current load,
  // and the expected registered outputs.
  bit [DEPTH-1:0] m_tab;
  bit             m_loaded, m_err, m_ov, m_od;
  int             m_count;
  bit             chk_en = 1'b0;

  always @(posedge clk) begin
    bit acc;
    bit good;
    if (!rst_n) begin
      m_loaded = 1'b0;
      m_err    = 1'b0;
      m_ov     = 1'b0;
      m_od     = 1'b0;
      m_count  = 0;
    end else begin
      // Lookup sees the table and armed flag as they were before this edge.
      if (in_valid) m_od = m_loaded ? m_tab[in_data] : 1'b0;
      m_ov = in_valid;
      acc   = cfg_valid && !m_err;
      m_err = 1'b0;
      if (acc) begin
        good = (cfg_last == (m_count == WORDS - 1));
        if (good) begin
          for (int j = 0; j < CFG_W; j++) m_tab[m_count * CFG_W + j] = cfg_data[j];
          if (cfg_last) begin
            m_loaded = 1'b1;
            m_count  = 0;
          end else begin
            m_loaded = 1'b0;
            m_count++;
          end
        end else begin
          m_err    = 1'b1;
          m_loaded = 1'b0;
          m_count  = 0;
        end
      end
    end
    chk_en = 1'b1;
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cfg_ready", cfg_ready, !m_err);
      chk("cfg_err",   cfg_err,   m_err);
      chk("loaded",    loaded,    m_loaded);
      chk("out_valid", out_valid, m_ov);
      if (m_ov) chk("out_data", out_data, m_od);
    end
  end

  // ---------------- driver tasks ----------------
  logic [CFG_W-1:0] words [WORDS];

  task automatic idle();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
  endtask

  // Send n beats from words[]; cfg_last on beat index last_at (-1 = never).
  task automatic load_words(input int n, input int last_at);
    for (int k = 0; k < n; k++) begin
      cfg_valid = 1'b1;
      cfg_data  = words[k];
      cfg_last  = (k == last_at);
      @(negedge clk);
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  task automatic look(input logic [IN_BITS-1:0] a, input logic exp, input string name);
    cfg_valid = 1'b0;
    in_valid  = 1'b1;
    in_data   = a;
    @(negedge clk);
    chk(name, out_data, exp);
    in_valid  = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    cfg_last  = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hA5;

    // Reset: two cycles held, lookup requested throughout.
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", out_valid, 1'b1);
    chk("post_rst_out_data",  out_data,  1'b0);
    chk("post_rst_loaded",    loaded,    1'b0);
    in_valid = 1'b0;

    // Full load: entry 33k set for k = 0..7.
    for (int k = 0; k < WORDS; k++) words[k] = 32'h1 << k;
    load_words(WORDS, WORDS - 1);
    chk("full_loaded", loaded, 1'b1);
    look(8'd66, 1'b1, "full_lut66");
    look(8'd67, 1'b0, "full_lut67");
    look(8'd231, 1'b1, "full_lut231");

    // Early last on beat 3.
    for (int k = 0; k < WORDS; k++) words[k] = '1;
    load_words(4, 3);
    chk("early_err",   cfg_err,   1'b1);
    chk("early_ready", cfg_ready, 1'b0);
    chk("early_loaded", loaded,   1'b0);
    idle();
    chk("early_err_gone", cfg_err,   1'b0);
    chk("early_ready_back", cfg_ready, 1'b1);
    look(8'd66, 1'b0, "early_masked66");

    // Missing last: error on beat 7, then a clean load.
    load_words(WORDS, -1);
    chk("miss_err", cfg_err, 1'b1);
    idle();
    for (int k = 0; k < WORDS; k++) words[k] = 32'hFFFF_0000;
    load_words(WORDS, WORDS - 1);
    chk("miss_reload_loaded", loaded, 1'b1);
    look(8'd16,  1'b1, "miss_lut16");
    look(8'd5,   1'b0, "miss_lut5");
    look(8'd240, 1'b1, "miss_lut240");

    // Reload while armed: all-ones armed, then an all-zero load.
    for (int k = 0; k < WORDS; k++) words[k] = '1;
    load_words(WORDS, WORDS - 1);
    chk("ones_loaded", loaded, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int k = 0; k < WORDS; k++) begin
      cfg_valid = 1'b1;
      cfg_data  = '0;
      cfg_last  = (k == WORDS - 1);
      @(negedge clk);
      if (k == 0) chk("reload_first_beat_old", out_data, 1'b1);
      else        chk("reload_masked",         out_data, 1'b0);
    end
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    in_valid  = 1'b0;
    chk("zeros_loaded", loaded, 1'b1);
    look(8'hFF, 1'b0, "zeros_lutFF");

    // Mid-load reset after beat 5, then a fresh load.
    for (int k = 0; k < WORDS; k++) words[k] = 32'hAAAA_AAAA;
    load_words(6, -1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_loaded", loaded, 1'b0);
    rst_n = 1'b1;
    idle();
    for (int k = 0; k < WORDS; k++) words[k] = 32'h0000_0100;
    load_words(WORDS, WORDS - 1);
    chk("midrst_reload_loaded", loaded, 1'b1);
    look(8'd8,   1'b1, "midrst_lut8");
    look(8'd40,  1'b1, "midrst_lut40");
    look(8'd9,   1'b0, "midrst_lut9");
    look(8'd232, 1'b1, "midrst_lut232");

    idle();
    idle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
